tcdm_mem_responder: RTL



---
 rtl/tcdm_mem_responder.sv | 92 +++++++++
 1 files changed

// File: rtl/tcdm_mem_responder.sv
// TCDM memory-side responder: round-robin arbitration of NB_PORTS requesters onto a
// single-ported word memory, fixed one-cycle response, optional LFSR-driven grant stalls.
module tcdm_mem_responder #(
    parameter int          NB_PORTS   = 3,
    parameter int          ADDR_WIDTH = 10,
    parameter int          DATA_WIDTH = 32,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NB_PORTS-1:0]                   tcdm_req,
    output logic [NB_PORTS-1:0]                   tcdm_gnt,
    input  logic [NB_PORTS-1:0][31:0]             tcdm_add,
    input  logic [NB_PORTS-1:0]                   tcdm_wen,
    input  logic [NB_PORTS-1:0][DATA_WIDTH/8-1:0] tcdm_be,
    input  logic [NB_PORTS-1:0][DATA_WIDTH-1:0]   tcdm_data,
    output logic [NB_PORTS-1:0][DATA_WIDTH-1:0]   tcdm_r_data,
    output logic [NB_PORTS-1:0]                   tcdm_r_valid,
    input  logic                                  stall_en,
    output logic                                  busy_o
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int PTR_WIDTH = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]                 mem [DEPTH];
    logic [PTR_WIDTH-1:0]                  rr_ptr;
    logic [PTR_WIDTH-1:0]                  sel;
    logic [15:0]                           lfsr;
    logic                                  stall;
    logic                                  granted;
    int                                    cand;
    logic [ADDR_WIDTH-1:0]                 idx;
    logic [NB_PORTS-1:0]                   r_valid_q;
    logic [NB_PORTS-1:0][DATA_WIDTH-1:0]   r_data_q;
    logic                                  addr_unused;

    assign stall       = stall_en & lfsr[0];
    assign idx         = tcdm_add[sel][ADDR_WIDTH+1:2];
    assign addr_unused = ^tcdm_add;

    // Search from the round-robin pointer upward; the first requester found wins.
    always_comb begin
        tcdm_gnt = '0;
        sel      = '0;
        granted  = 1'b0;
        cand     = 0;
        if (!rst_i && !stall) begin
            for (int i = 0; i < NB_PORTS; i++) begin
                cand = (int'(rr_ptr) + i) % NB_PORTS;
                if (!granted && tcdm_req[cand]) begin
                    granted        = 1'b1;
                    sel            = PTR_WIDTH'(cand);
                    tcdm_gnt[cand] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr    <= '0;
            lfsr      <= LFSR_SEED;
            r_valid_q <= '0;
            r_data_q  <= '0;
        end else begin
            lfsr      <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            r_valid_q <= tcdm_gnt;
            if (granted) begin
                rr_ptr        <= (int'(sel) == NB_PORTS - 1) ? '0 : sel + PTR_WIDTH'(1);
                r_data_q[sel] <= tcdm_wen[sel] ? mem[idx] : '0;
            end
        end
    end

    // Memory contents survive reset; only byte lanes with be set are written.
    always_ff @(posedge clk_i) begin
        if (granted && !tcdm_wen[sel]) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (tcdm_be[sel][b]) begin
                    mem[idx][8*b +: 8] <= tcdm_data[sel][8*b +: 8];
                end
            end
        end
    end

    assign tcdm_r_valid = r_valid_q;
    assign tcdm_r_data  = r_data_q;
    assign busy_o       = |r_valid_q;

endmodule
